tx_frame_scheduler: RTL and testbench
=====================================

# tx_frame_scheduler

Round-robin scheduler that shares one UART transmit datapath (`Dataflow_Tx`) between up to REQ requesters. It picks one pending requester at a time and latches that requester's byte and parity configuration. It then pulses the datapath's start input and holds the datapath inputs stable for the full serial frame. After an optional inter-frame gap it re-arbitrates. The block sits between the requesting client blocks and the `Dataflow_Tx` instance. It owns that instance's `start_sig`, `D`, `parity_check` and `parity_type_even_odd` inputs.

## Interface
- `N`, 8: data width per frame; must match the datapath's `n`.
- `REQ`, 4: number of requesters, 2..8.
- `GAP`, 1: idle cycles inserted after each frame, 0..15.

- `clk`  in  1  system clock; the datapath shifts one bit per cycle.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  REQ  per-requester frame request, level.
- `data_in`  in  REQ*N  requester i's byte on bits [i*N +: N].
- `par_en`  in  REQ  requester i wants a parity bit.
- `par_odd`  in  REQ  requester i parity type (1 = odd, 0 = even).
- `grant`  out  REQ  one-hot, one-cycle pulse; marks the requester whose frame starts.
- `done`  out  1  one-cycle pulse after the last frame bit cycle.
- `busy`  out  1  high whenever state ≠ IDLE.
- `tx_start`  out  1  to datapath `start_sig`.
- `tx_data`  out  N  to datapath `D`.
- `tx_parity_check`  out  1  to datapath `parity_check`.
- `tx_parity_odd`  out  1  to datapath `parity_type_even_odd`.

## Operation
- States: IDLE, START, SEND, GAP.
- IDLE:
  - If `req` ≠ 0, select the first set bit searching from `ptr+1` upward, wrapping modulo REQ.
  - Latch that requester's `data_in` slice, `par_en` and `par_odd`.
  - Set `ptr` to the selected index and go to START.
  - Otherwise stay in IDLE.
- START lasts exactly 1 cycle: `tx_start`=1 and `grant[sel]`=1. Load the bit counter with FL−1, where FL = N+2+par_en_latched. Go to SEND.
- SEND lasts FL cycles, with the counter decrementing to 0. At 0, go to GAP if GAP>0, else to IDLE.
- GAP lasts GAP cycles, counted with a separate counter, then goes to IDLE.
- `done` is registered and is high for one cycle, namely the first cycle after the final SEND cycle.
- `tx_data`, `tx_parity_check` and `tx_parity_odd` are driven from the latched values. They stay constant from START through the last SEND cycle and are 0 in IDLE and GAP.
- Requester protocol:
  - A requester holds `req` until it sees its `grant` pulse.
  - Deasserting `req` before the grant withdraws the request without side effects.
  - Keeping `req` high after the grant requests another frame.
- `data_in`, `par_en` and `par_odd` are sampled only in the IDLE decision cycle. Later changes do not affect the frame in flight.
- Requests arriving during START, SEND or GAP wait until the next IDLE cycle. Nothing is queued.

## Timing
- Reset values (in effect the cycle after `rst` is sampled high):
  - State IDLE, `ptr` = REQ−1, so requester 0 wins first.
  - Both counters 0.
  - All outputs 0: `grant`, `done`, `busy`, `tx_start`, `tx_data`, `tx_parity_check`, `tx_parity_odd`.
- Reset mid-frame aborts the frame immediately and does not produce `done`. The system reset clears the datapath in the same cycle.
- `rst` has priority over every other input.
- Latency: with `req` sampled in IDLE at edge k, `tx_start`/`grant` are high in cycle k+1.
- Frame period while requests are continuously pending: 1 (IDLE) + 1 (START) + FL + GAP cycles.
  - N=8, parity on, GAP=1: 14 cycles.
  - N=8, parity off, GAP=0: 12 cycles.
- `grant` is never asserted for more than one bit at a time, and only together with `tx_start`.
- Arithmetic: the bit counter is clog2(N+3) bits wide; the gap counter is 4 bits. Neither wraps, because each is loaded before it counts down.

## Test plan
- Reset: hold `rst` for 2 cycles with all `req`=1 → all outputs 0 and `busy`=0 while reset is high. After release, `grant`=0001 appears on the second cycle.
- Single frame (N=8, GAP=1): `req`=0010, `data_in[15:8]`=0x55, `par_en[1]`=1, `par_odd[1]`=0 →
  - `tx_start`=1 for exactly 1 cycle with `grant`=0010 and `tx_data`=0x55, `tx_parity_check`=1, `tx_parity_odd`=0.
  - Data held for 11 further SEND cycles; `done` pulses on the next cycle.
  - `busy` high for 13 cycles total.
- No parity: same as the single-frame case with `par_en[1]`=0 → SEND lasts 10 cycles and `done` comes 1 cycle earlier.
- Fairness: `req`=1111 held constantly → grants in order 0001, 0010, 0100, 1000, 0001, spaced 14 cycles apart.
- Skip and withdraw:
  - With `ptr`=1 and `req`=1010 → grant 1000 first, then 0010.
  - Dropping `req[3]` during the first frame → the next grant is 0010.
- Mid-frame reset: assert `rst` in SEND cycle 5 of a requester-2 frame →
  - The next cycle has all outputs 0 and no `done`.
  - After release with `req`=0101 → `grant`=0001 (pointer was reset).

Source files
------------

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: round-robin arbiter that owns the inputs of a shared
// UART transmit datapath. It grants one requester at a time, latches that
// requester's byte and parity setup, pulses start, and holds the datapath
// inputs steady for the whole serial frame, followed by an optional idle gap.
module tx_frame_scheduler #(
  parameter int N   = 8,
  parameter int REQ = 4,
  parameter int GAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ-1:0]   req,
  input  logic [REQ*N-1:0] data_in,
  input  logic [REQ-1:0]   par_en,
  input  logic [REQ-1:0]   par_odd,
  output logic [REQ-1:0]   grant,
  output logic             done,
  output logic             busy,
  output logic             tx_start,
  output logic [N-1:0]     tx_data,
  output logic             tx_parity_check,
  output logic             tx_parity_odd
);

  localparam int   PW      = (REQ > 1) ? $clog2(REQ) : 1;
  localparam int   CW      = $clog2(N + 3);
  localparam logic HAS_GAP = (GAP > 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SEND  = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]      gap_cnt_q, gap_cnt_d;
  logic [N-1:0]    data_q, data_d;
  logic            par_en_q, par_en_d;
  logic            par_odd_q, par_odd_d;

  logic [PW:0]     cand_s;
  logic            found_s;
  logic [PW-1:0]   sel_s;
  logic [N-1:0]    sel_data_s;

  logic [REQ-1:0]  grant_q, grant_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            tx_start_q, tx_start_d;
  logic [N-1:0]    tx_data_q, tx_data_d;
  logic            tx_pc_q, tx_pc_d;
  logic            tx_po_q, tx_po_d;
  logic            hold_s;

  // Round-robin search: first pending requester strictly after ptr, wrapping.
  always_comb begin
    found_s = 1'b0;
    sel_s   = ptr_q;
    cand_s  = '0;
    for (int i = 1; i <= REQ; i++) begin
      cand_s = {1'b0, ptr_q} + (PW+1)'(i);
      cand_s = (cand_s >= (PW+1)'(REQ)) ? (cand_s - (PW+1)'(REQ)) : cand_s;
      if (!found_s && req[cand_s[PW-1:0]]) begin
        found_s = 1'b1;
        sel_s   = cand_s[PW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pick the selected requester's byte out of the packed data bus.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < REQ; i++) begin
      if (sel_s == PW'(i)) begin
        sel_data_s = data_in[i*N +: N];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Next-state logic: arbitration, frame bit counting and inter-frame gap.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d   = S_START;
          ptr_d     = sel_s;
          data_d    = sel_data_s;
          par_en_d  = par_en[sel_s];
          par_odd_d = par_odd[sel_s];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        // Frame length is start + N data + optional parity + stop.
        bit_cnt_d = CW'(N + 1) + CW'(par_en_q);
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (bit_cnt_q == '0) begin
          if (HAS_GAP) begin
            state_d   = S_GAP;
            gap_cnt_d = 4'(GAP - 1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    hold_s     = (state_d == S_START) || (state_d == S_SEND);
    tx_start_d = (state_d == S_START);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_q == S_SEND) && (bit_cnt_q == '0);
    tx_data_d  = hold_s ? data_d : '0;
    tx_pc_d    = hold_s ? par_en_d : 1'b0;
    tx_po_d    = hold_s ? par_odd_d : 1'b0;
    grant_d    = '0;
    for (int i = 0; i < REQ; i++) begin
      grant_d[i] = tx_start_d && (ptr_d == PW'(i));
    end
  end

  // Control state, pointer, counters and latched frame configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= PW'(REQ - 1);
      bit_cnt_q <= '0;
      gap_cnt_q <= 4'd0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
    end
  end

  // Registered outputs toward the requesters and the transmit datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      tx_pc_q    <= 1'b0;
      tx_po_q    <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      tx_pc_q    <= tx_pc_d;
      tx_po_q    <= tx_po_d;
    end
  end

  assign grant           = grant_q;
  assign done            = done_q;
  assign busy            = busy_q;
  assign tx_start        = tx_start_q;
  assign tx_data         = tx_data_q;
  assign tx_parity_check = tx_pc_q;
  assign tx_parity_odd   = tx_po_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Self-checking bench for tx_frame_scheduler. Expected frames are queued when
// requests are driven and compared when the scheduler starts each frame.
module tb_tx_frame_scheduler;

  localparam int N   = 8;
  localparam int REQ = 4;
  localparam int GAP = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [REQ-1:0]   req;
  logic [REQ*N-1:0] data_in;
  logic [REQ-1:0]   par_en;
  logic [REQ-1:0]   par_odd;
  logic [REQ-1:0]   grant;
  logic             done;
  logic             busy;
  logic             tx_start;
  logic [N-1:0]     tx_data;
  logic             tx_parity_check;
  logic             tx_parity_odd;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [REQ-1:0] g;
    logic [N-1:0]   d;
    logic           pc;
    logic           po;
  } frame_t;

  frame_t exp_q[$];

  tx_frame_scheduler #(.N(N), .REQ(REQ), .GAP(GAP)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .data_in         (data_in),
    .par_en          (par_en),
    .par_odd         (par_odd),
    .grant           (grant),
    .done            (done),
    .busy            (busy),
    .tx_start        (tx_start),
    .tx_data         (tx_data),
    .tx_parity_check (tx_parity_check),
    .tx_parity_odd   (tx_parity_odd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(negedge clk);
  endtask

  function automatic frame_t mk(input int r);
    frame_t f;
    f.g  = REQ'(1) << r;
    f.d  = data_in[r*N +: N];
    f.pc = par_en[r];
    f.po = par_odd[r];
    return f;
  endfunction

  task automatic wait_start(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no tx_start within 200 cycles, expected a frame start", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  // Called at the START cycle: checks the start beat, every SEND beat, done and idle.
  task automatic check_frame(input string name);
    frame_t e;
    int fl;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected frame start grant=%b, expected none", name, grant);
      return;
    end
    e  = exp_q.pop_front();
    fl = N + 2 + int'(e.pc);
    checks++;
    if (grant !== e.g) begin
      errors++;
      $display("FAIL %s grant: got %b expected %b", name, grant, e.g);
    end
    checks++;
    if ({tx_data, tx_parity_check, tx_parity_odd, busy} !== {e.d, e.pc, e.po, 1'b1}) begin
      errors++;
      $display("FAIL %s start: got data=%h pc=%b po=%b busy=%b expected %h %b %b 1",
               name, tx_data, tx_parity_check, tx_parity_odd, busy, e.d, e.pc, e.po);
    end
    for (int k = 0; k < fl; k++) begin
      step();
      checks++;
      if ({tx_start, grant, done, busy, tx_data, tx_parity_check, tx_parity_odd} !==
          {1'b0, REQ'(0), 1'b0, 1'b1, e.d, e.pc, e.po}) begin
        errors++;
        $display("FAIL %s send%0d: got start=%b grant=%b done=%b busy=%b data=%h pc=%b po=%b expected 0 0 0 1 %h %b %b",
                 name, k, tx_start, grant, done, busy, tx_data, tx_parity_check, tx_parity_odd,
                 e.d, e.pc, e.po);
      end
    end
    step();
    checks++;
    if ({done, tx_start, busy, tx_data, tx_parity_check, tx_parity_odd} !==
        {1'b1, 1'b0, 1'b1, N'(0), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s done/gap: got done=%b start=%b busy=%b data=%h pc=%b po=%b expected 1 0 1 00 0 0",
               name, done, tx_start, busy, tx_data, tx_parity_check, tx_parity_odd);
    end
    step();
    checks++;
    if ({done, busy, tx_start} !== 3'b000) begin
      errors++;
      $display("FAIL %s idle: got done=%b busy=%b start=%b expected 0 0 0", name, done, busy, tx_start);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    req     = 4'b1111;
    data_in = 32'h44332211;
    par_en  = 4'b0101;
    par_odd = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({grant, done, busy, tx_start, tx_data, tx_parity_check, tx_parity_odd} !== '0) begin
        errors++;
        $display("FAIL reset%0d: got grant=%b done=%b busy=%b start=%b data=%h pc=%b po=%b expected all 0",
                 i, grant, done, busy, tx_start, tx_data, tx_parity_check, tx_parity_odd);
      end
    end
    rst = 1'b0;
    exp_q.push_back(mk(0));
    step();
    checks++;
    if ({tx_start, grant} !== {1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL reset_release: got start=%b grant=%b expected 1 0001", tx_start, grant);
      void'(exp_q.pop_front());
    end else begin
      req = 4'b0000;
      check_frame("reset_first");
    end
  endtask

  task automatic test_single_frame(input string name, input logic par);
    bit ok;
    req             = 4'b0010;
    data_in[15:8]   = 8'h55;
    par_en[1]       = par;
    par_odd[1]      = 1'b0;
    exp_q.push_back(mk(1));
    wait_start(name, ok);
    if (ok) begin
      req           = 4'b0000;
      data_in[15:8] = 8'hAA;
      par_en[1]     = ~par;
      par_odd[1]    = 1'b1;
      check_frame(name);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    int last;
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst     = 1'b0;
    data_in = 32'hD4C3B2A1;
    par_en  = 4'b1111;
    par_odd = 4'b1010;
    req     = 4'b1111;
    exp_q.push_back(mk(0));
    exp_q.push_back(mk(1));
    exp_q.push_back(mk(2));
    exp_q.push_back(mk(3));
    exp_q.push_back(mk(0));
    last = 0;
    for (int i = 0; i < 5; i++) begin
      wait_start("fair", ok);
      if (ok) begin
        if (i == 4) req = 4'b0000;
        if (i > 0) begin
          checks++;
          if (cyc - last !== 14) begin
            errors++;
            $display("FAIL fair_period%0d: got %0d cycles expected 14", i, cyc - last);
          end
        end
        last = cyc;
        check_frame("fair");
      end
    end
  endtask

  task automatic test_skip_withdraw();
    bit ok;
    req = 4'b0010;
    exp_q.push_back(mk(1));
    wait_start("skip_setup", ok);
    if (ok) begin
      req = 4'b0000;
      check_frame("skip_setup");
    end
    data_in[31:24] = 8'hC3;
    par_en[3]      = 1'b1;
    par_odd[3]     = 1'b1;
    data_in[15:8]  = 8'h3C;
    par_en[1]      = 1'b0;
    par_odd[1]     = 1'b0;
    req            = 4'b1010;
    exp_q.push_back(mk(3));
    wait_start("skip_first", ok);
    if (ok) begin
      req = 4'b0010;
      exp_q.push_back(mk(1));
      check_frame("skip_first");
    end
    wait_start("skip_second", ok);
    if (ok) begin
      req = 4'b0000;
      check_frame("skip_second");
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    frame_t e;
    req            = 4'b0100;
    data_in[23:16] = 8'h96;
    par_en[2]      = 1'b1;
    par_odd[2]     = 1'b0;
    exp_q.push_back(mk(2));
    wait_start("midrst", ok);
    if (ok) begin
      req = 4'b0000;
      e   = exp_q.pop_front();
      checks++;
      if ({grant, tx_data} !== {e.g, e.d}) begin
        errors++;
        $display("FAIL midrst_start: got grant=%b data=%h expected %b %h", grant, tx_data, e.g, e.d);
      end
      for (int k = 0; k < 5; k++) step();
      rst           = 1'b1;
      req           = 4'b0101;
      data_in[7:0]  = 8'h5A;
      par_en[0]     = 1'b0;
      par_odd[0]    = 1'b1;
      step();
      checks++;
      if ({grant, done, busy, tx_start, tx_data, tx_parity_check, tx_parity_odd} !== '0) begin
        errors++;
        $display("FAIL midrst_abort: got grant=%b done=%b busy=%b start=%b data=%h expected all 0",
                 grant, done, busy, tx_start, tx_data);
      end
      rst = 1'b0;
      exp_q.push_back(mk(0));
      step();
      checks++;
      if (tx_start !== 1'b1) begin
        errors++;
        $display("FAIL midrst_release: got start=%b expected 1", tx_start);
        void'(exp_q.pop_front());
      end else begin
        req = 4'b0000;
        check_frame("midrst_after");
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    req     = 4'b1111;
    data_in = '0;
    par_en  = '0;
    par_odd = '0;
    test_reset();
    test_single_frame("single_par", 1'b1);
    test_single_frame("single_nopar", 1'b0);
    test_fairness();
    test_skip_withdraw();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d unserved frames expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
